amux_bus_arbiter: RTL and testbench
===================================

# amux_bus_arbiter

Arbitrates pad access to the two shared analog mux buses (AMUXBUS_A, AMUXBUS_B) among N pad requesters. Drives the per-pad analog switch enables with round-robin fairness and break-before-make sequencing, so two pads are never shorted through a bus. It sits in the chip-level I/O ring control logic, between the core-side analog requesters and the pad-cell switch enables.

## Interface
Parameters:
- N_REQ, 4 — number of pad requesters (2..16).
- SETTLE_CYC, 8 — cycles from switch-enable to grant (bus settle), ≥1.
- BBM_CYC, 4 — dead cycles with all switches on a bus off before the next owner, ≥1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- amux_off  in  1  force-release both buses (power-down / VSWITCH low).
- req_a  in  N_REQ  per-pad request for bus A (level, held while using).
- req_b  in  N_REQ  per-pad request for bus B.
- grant_a  out  N_REQ  one-hot-or-zero grant, bus A.
- grant_b  out  N_REQ  one-hot-or-zero grant, bus B.
- sw_a_en  out  N_REQ  pad-to-AMUXBUS_A switch enables, one-hot-or-zero.
- sw_b_en  out  N_REQ  pad-to-AMUXBUS_B switch enables, one-hot-or-zero.
- busy_a, busy_b  out  1  bus not in IDLE.

## Operation
- Two independent per-bus FSMs: IDLE, MAKE, OWNED, BREAK.
- IDLE: if any eligible request, pick winner round-robin starting at last_owner+1 (mod N_REQ). Go to MAKE; sw_x_en[winner]=1 from the next cycle.
- MAKE: switch on, grant low; count SETTLE_CYC cycles, then OWNED. If req drops during MAKE → BREAK.
- OWNED: sw_x_en and grant_x for the owner both high. Owner drops req → BREAK.
- BREAK: all sw_x_en and grants 0 for BBM_CYC cycles, then IDLE. last_owner updates on entry to BREAK.
- Cross-bus exclusion: pad i is not eligible on bus B while it holds sw_a_en[i] (and vice versa). If both buses pick the same pad in the same IDLE cycle, bus A wins; bus B excludes that pad in that cycle and picks the next eligible pad, or stays IDLE if none.
- amux_off=1: both FSMs in MAKE/OWNED go to BREAK next cycle. IDLE does not arbitrate while amux_off=1. BREAK completes normally.
- Reset: state IDLE, last_owner=N_REQ-1 (so pad 0 is first), counters 0.

## Timing
- Reset values: grant_a/b=0, sw_a_en/sw_b_en=0, busy_a/b=0.
- All outputs are registered: FSM state plus decoded owner index.
- Request to switch-on latency: 1 cycle (req sampled at edge k, sw_en high after edge k+1).
- Switch-on to grant: SETTLE_CYC cycles. Request to grant: 1+SETTLE_CYC.
- Req drop to grant/switch low: 1 cycle.
- Switch off to next switch on (same bus): BBM_CYC+1 cycles minimum (BREAK count plus the IDLE arbitration cycle).
- Counters are width $clog2(max(SETTLE_CYC,BBM_CYC)+1), saturating, reload on state entry.
- Async reset mid-MAKE/OWNED drops all switches immediately, with no BBM. This is acceptable because all switches go off together.

## Structure
- Package amux_arb_pkg: state enum type (IDLE/MAKE/OWNED/BREAK) and a round-robin pick function (request vector, last index → index, valid).
- Sub-module amux_bus_fsm: one bus FSM with counter, last_owner and exclude-mask input. Top instantiates it twice and wires exclusion: A's mask is sw_b_en; B's mask is sw_a_en OR A's same-cycle pick.

## Test plan
- Single request: N_REQ=4, SETTLE=8, BBM=4; req_a=0001 → sw_a_en=0001 at cycle 1, grant_a=0001 at cycle 9. Drop req → both 0 at the next cycle; busy_a low 5 cycles later.
- Round-robin: req_a=1111 held and each owner releases after grant → owners 0,1,2,3,0. sw_a_en never has two bits set, and there are ≥5 zero cycles between owners.
- Cross-bus conflict: req_a=req_b=0010 together → A owns pad 1 and B stays IDLE. Then add req_b bit 2 → B grants pad 2 while A still owns pad 1.
- amux_off during OWNED on both buses → all sw/grant 0 next cycle; no new MAKE until amux_off=0 and BBM done.
- Req drop during MAKE (cycle 3 of 8) → grant never rises, sw off next cycle, BREAK 4 cycles.
- Async reset asserted in OWNED → outputs 0 immediately. After release, req_a=1111 → pad 0 wins.

Source files
------------

// File: rtl/amux_arb_pkg.sv
// Shared types for the analog mux bus arbiter: per-bus FSM states and the
// round-robin winner selection used by each bus.
package amux_arb_pkg;

  localparam int RR_MAX_REQ = 16;
  localparam int RR_IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAKE  = 2'd1,
    ST_OWNED = 2'd2,
    ST_BREAK = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req searching from last+1 upward, wrapping at n_req.
  // The loop runs downward so the nearest candidate is the final write.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [RR_IDX_W-1:0]   last,
                                       input int                    n_req);
    rr_pick_t            res;
    int                  cand;
    logic [RR_IDX_W-1:0] cidx;
    res = '0;
    for (int k = RR_MAX_REQ; k >= 1; k--) begin
      if (k <= n_req) begin
        cand = (int'(last) + k) % n_req;
        cidx = cand[RR_IDX_W-1:0];
        if (req[cidx]) begin
          res.valid = 1'b1;
          res.idx   = cidx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/amux_bus_fsm.sv
// One analog-mux bus: round-robin arbitration, make (settle) phase, ownership
// and break-before-make dead time. Outputs decode from registered state/owner.
module amux_bus_fsm
  import amux_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 8,
  parameter int BBM_CYC    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             amux_off,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] excl_mask,
  output logic [N_REQ-1:0] sw_en,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] pick,
  output logic             busy
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (SETTLE_CYC > BBM_CYC) ? SETTLE_CYC : BBM_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BBM_LAST    = CNT_W'(BBM_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);

  bus_state_e           state_reg, state_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [IDX_W-1:0]     last_reg, last_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  logic [RR_MAX_REQ-1:0] elig;
  rr_pick_t              pick_res;
  logic [IDX_W-1:0]      pick_idx;
  logic                  arb_en;
  logic                  owner_lost;

  assign elig     = RR_MAX_REQ'(req & ~excl_mask);
  assign pick_res = rr_pick(elig, RR_IDX_W'(last_reg), N_REQ);
  assign pick_idx = IDX_W'(pick_res.idx);
  assign arb_en   = (state_reg == ST_IDLE) && !amux_off && pick_res.valid;
  // Power-down or the owner letting go both end the connection the same way.
  assign owner_lost = amux_off || !req[owner_reg];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
      last_reg  <= IDX_W'(N_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = (cnt_reg == CNT_TOP) ? cnt_reg : cnt_reg + 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (arb_en) begin
          state_next = ST_MAKE;
          owner_next = pick_idx;
          cnt_next   = '0;
        end
      end
      ST_MAKE: begin
        if (owner_lost) begin
          state_next = ST_BREAK;
          last_next  = owner_reg;
          cnt_next   = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          state_next = ST_OWNED;
          cnt_next   = '0;
        end
      end
      ST_OWNED: begin
        if (owner_lost) begin
          state_next = ST_BREAK;
          last_next  = owner_reg;
          cnt_next   = '0;
        end
      end
      ST_BREAK: begin
        if (cnt_reg == BBM_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign sw_en[gi] = ((state_reg == ST_MAKE) || (state_reg == ST_OWNED)) &&
                         (owner_reg == IDX_W'(gi));
      assign grant[gi] = (state_reg == ST_OWNED) && (owner_reg == IDX_W'(gi));
      assign pick[gi]  = arb_en && (pick_idx == IDX_W'(gi));
    end
  endgenerate

  assign busy = (state_reg != ST_IDLE);

endmodule

// File: rtl/amux_bus_arbiter.sv
// Arbiter for the two shared analog mux buses. Each bus runs its own FSM; a pad
// already switched onto one bus (or picked by bus A this cycle) is hidden from the other.
module amux_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 8,
  parameter int BBM_CYC    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             amux_off,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] grant_a,
  output logic [N_REQ-1:0] grant_b,
  output logic [N_REQ-1:0] sw_a_en,
  output logic [N_REQ-1:0] sw_b_en,
  output logic             busy_a,
  output logic             busy_b
);

  logic [N_REQ-1:0] pick_a;
  logic [N_REQ-1:0] pick_b_unused;
  logic [N_REQ-1:0] mask_b;

  // Bus A wins a same-cycle tie, so its fresh pick is masked out of bus B.
  assign mask_b = sw_a_en | pick_a;

  amux_bus_fsm #(
    .N_REQ      (N_REQ),
    .SETTLE_CYC (SETTLE_CYC),
    .BBM_CYC    (BBM_CYC)
  ) u_bus_a (
    .clk       (clk),
    .resetn    (resetn),
    .amux_off  (amux_off),
    .req       (req_a),
    .excl_mask (sw_b_en),
    .sw_en     (sw_a_en),
    .grant     (grant_a),
    .pick      (pick_a),
    .busy      (busy_a)
  );

  amux_bus_fsm #(
    .N_REQ      (N_REQ),
    .SETTLE_CYC (SETTLE_CYC),
    .BBM_CYC    (BBM_CYC)
  ) u_bus_b (
    .clk       (clk),
    .resetn    (resetn),
    .amux_off  (amux_off),
    .req       (req_b),
    .excl_mask (mask_b),
    .sw_en     (sw_b_en),
    .grant     (grant_b),
    .pick      (pick_b_unused),
    .busy      (busy_b)
  );

endmodule

// File: tb/tb_amux_bus_arbiter.sv
// Bench for amux_bus_arbiter: directed scenarios plus randomized traffic checked
// against a timestamp-based reference model of each bus.
module tb_amux_bus_arbiter;

  localparam int N      = 4;
  localparam int SETTLE = 8;
  localparam int BBM    = 4;
  localparam int VW     = 4 * N + 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         amux_off;
  logic [N-1:0] req_a, req_b;
  logic [N-1:0] grant_a, grant_b, sw_a_en, sw_b_en;
  logic         busy_a, busy_b;

  always #5 clk = ~clk;

  amux_bus_arbiter #(
    .N_REQ      (N),
    .SETTLE_CYC (SETTLE),
    .BBM_CYC    (BBM)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .amux_off (amux_off),
    .req_a    (req_a),
    .req_b    (req_b),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .sw_a_en  (sw_a_en),
    .sw_b_en  (sw_b_en),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model per bus: current owner (-1 none), cycle the switch closed, cycle it
  // opened, last owner. Grant and busy follow from elapsed time.
  int m_owner[2];
  int m_on[2];
  int m_off[2];
  int m_last[2];
  int cyc;

  function automatic int rr_ref(input logic [N-1:0] elig, input int last);
    for (int k = 1; k <= N; k++)
      if (elig[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] bit_of(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  function automatic logic [VW-1:0] expected();
    logic [N-1:0] sw[2];
    logic [N-1:0] gr[2];
    logic         bz[2];
    for (int b = 0; b < 2; b++) begin
      sw[b] = bit_of(m_owner[b]);
      gr[b] = (m_owner[b] >= 0 && cyc >= m_on[b] + SETTLE) ? sw[b] : '0;
      bz[b] = (m_owner[b] >= 0) || (cyc < m_off[b] + BBM);
    end
    return {gr[0], gr[1], sw[0], sw[1], bz[0], bz[1]};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {grant_a, grant_b, sw_a_en, sw_b_en, busy_a, busy_b};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_owner[b] = -1;
      m_on[b]    = 0;
      m_off[b]   = -BBM;
      m_last[b]  = N - 1;
    end
    cyc = 0;
  endtask

  task automatic model_bus(input int b, input logic [N-1:0] r, input logic [N-1:0] mask,
                           input logic off, input int c, output logic [N-1:0] picked);
    int p;
    picked = '0;
    if (m_owner[b] >= 0) begin
      if (off || !r[m_owner[b]]) begin
        m_last[b]  = m_owner[b];
        m_owner[b] = -1;
        m_off[b]   = c + 1;
      end
    end else if (!off && c >= m_off[b] + BBM) begin
      p = rr_ref(r & ~mask, m_last[b]);
      if (p >= 0) begin
        m_owner[b] = p;
        m_on[b]    = c + 1;
        picked     = bit_of(p);
      end
    end
  endtask

  task automatic model_edge(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic off);
    logic [N-1:0] sa_pre, sb_pre, pick_a, pick_b;
    int c;
    c      = cyc;
    sa_pre = bit_of(m_owner[0]);
    sb_pre = bit_of(m_owner[1]);
    model_bus(0, ra, sb_pre, off, c, pick_a);
    model_bus(1, rb, sa_pre | pick_a, off, c, pick_b);
    cyc = c + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(req_a, req_b, amux_off);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    amux_off = 1'b0;
    req_a    = '0;
    req_b    = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    amux_off = 1'b0;
    req_a    = '0;
    req_b    = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (observed() !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h exp=%h", observed(), {VW{1'b0}});
    end
    resetn = 1'b1;
    model_reset();
    tick();
    tests_run++;
    if (observed() !== expected()) begin
      tests_failed++;
      $display("FAIL reset_idle got=%h exp=%h", observed(), expected());
    end
    $display("[TB] test_reset done, %0d checks so far", tests_run);
  endtask

  task automatic test_single();
    do_reset();
    req_a = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
      if (i == 1) begin
        tests_run++;
        if (sw_a_en !== 4'b0001) begin
          tests_failed++;
          $display("FAIL single_sw_on got=%b exp=0001", sw_a_en);
        end
      end
      if (i == 8) begin
        tests_run++;
        if (grant_a !== 4'b0000) begin
          tests_failed++;
          $display("FAIL single_grant_early got=%b exp=0000", grant_a);
        end
      end
    end
    tests_run++;
    if (grant_a !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_grant got=%b exp=0001", grant_a);
    end
    req_a = '0;
    tick();
    tests_run++;
    if ({sw_a_en, grant_a, busy_a} !== {4'b0000, 4'b0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_drop got=%b_%b_%b exp=0000_0000_1", sw_a_en, grant_a, busy_a);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL single_break cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
      if (i == 3 || i == 4) begin
        tests_run++;
        if (busy_a !== (i == 3)) begin
          tests_failed++;
          $display("FAIL single_busy i=%0d got=%b exp=%b", i, busy_a, (i == 3));
        end
      end
    end
    $display("[TB] test_single done, %0d checks so far", tests_run);
  endtask

  task automatic test_round_robin();
    int exp_owner[5] = '{0, 1, 2, 3, 0};
    int zeros;
    int waited;
    do_reset();
    req_a = '1;
    zeros = 0;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (grant_a === '0 && waited < 40) begin
        tick();
        waited++;
        if (sw_a_en === '0) zeros++;
        tests_run++;
        if (observed() !== expected() || $countones(sw_a_en) > 1) begin
          tests_failed++;
          $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, observed(), expected());
        end
      end
      tests_run++;
      if (grant_a !== bit_of(exp_owner[g])) begin
        tests_failed++;
        $display("FAIL rr_owner g=%0d got=%b exp=%b", g, grant_a, bit_of(exp_owner[g]));
      end
      if (g > 0) begin
        tests_run++;
        if (zeros < BBM + 1) begin
          tests_failed++;
          $display("FAIL rr_gap g=%0d got=%0d exp>=%0d", g, zeros, BBM + 1);
        end
      end
      req_a[exp_owner[g]] = 1'b0;
      tick();
      zeros = (sw_a_en === '0) ? 1 : 0;
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL rr_release cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
      req_a = '1;
    end
    $display("[TB] test_round_robin done, %0d checks so far", tests_run);
  endtask

  task automatic test_cross();
    do_reset();
    req_a = 4'b0010;
    req_b = 4'b0010;
    tick();
    tests_run++;
    if ({sw_a_en, sw_b_en, busy_b} !== {4'b0010, 4'b0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL cross_tie got=%b_%b_%b exp=0010_0000_0", sw_a_en, sw_b_en, busy_b);
    end
    repeat (2) tick();
    req_b = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (observed() !== expected() || (sw_a_en & sw_b_en) !== '0) begin
        tests_failed++;
        $display("FAIL cross_model cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
    end
    tests_run++;
    if ({grant_a, grant_b} !== {4'b0010, 4'b0100}) begin
      tests_failed++;
      $display("FAIL cross_grants got=%b_%b exp=0010_0100", grant_a, grant_b);
    end
    $display("[TB] test_cross done, %0d checks so far", tests_run);
  endtask

  task automatic test_amux_off();
    do_reset();
    req_a = 4'b0001;
    req_b = 4'b0010;
    repeat (10) tick();
    tests_run++;
    if ({grant_a, grant_b} !== {4'b0001, 4'b0010}) begin
      tests_failed++;
      $display("FAIL off_owned got=%b_%b exp=0001_0010", grant_a, grant_b);
    end
    amux_off = 1'b1;
    tick();
    tests_run++;
    if ({sw_a_en, sw_b_en, grant_a, grant_b, busy_a, busy_b} !== {16'h0000, 2'b11}) begin
      tests_failed++;
      $display("FAIL off_release got=%h exp=%h", {sw_a_en, sw_b_en, grant_a, grant_b, busy_a, busy_b}, {16'h0000, 2'b11});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (observed() !== expected() || (sw_a_en | sw_b_en) !== '0) begin
        tests_failed++;
        $display("FAIL off_hold cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
    end
    amux_off = 1'b0;
    tick();
    tests_run++;
    if ({sw_a_en, sw_b_en} !== {4'b0001, 4'b0010}) begin
      tests_failed++;
      $display("FAIL off_resume got=%b_%b exp=0001_0010", sw_a_en, sw_b_en);
    end
    $display("[TB] test_amux_off done, %0d checks so far", tests_run);
  endtask

  task automatic test_make_drop();
    do_reset();
    req_a = 4'b0001;
    repeat (3) tick();
    req_a = '0;
    tick();
    tests_run++;
    if ({sw_a_en, grant_a, busy_a} !== {4'b0000, 4'b0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL make_drop got=%b_%b_%b exp=0000_0000_1", sw_a_en, grant_a, busy_a);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++;
      if (observed() !== expected() || grant_a !== '0 || busy_a !== (i < 4)) begin
        tests_failed++;
        $display("FAIL make_break i=%0d got=%h exp=%h", i, observed(), expected());
      end
    end
    $display("[TB] test_make_drop done, %0d checks so far", tests_run);
  endtask

  task automatic test_async_reset();
    do_reset();
    req_a = 4'b0001;
    repeat (10) tick();
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (observed() !== '0) begin
      tests_failed++;
      $display("FAIL async_reset got=%h exp=%h", observed(), {VW{1'b0}});
    end
    req_a = '1;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    tick();
    tests_run++;
    if (sw_a_en !== 4'b0001 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL async_first got=%b exp=0001", sw_a_en);
    end
    $display("[TB] test_async_reset done, %0d checks so far", tests_run);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req_a[b] = ~req_a[b];
        if ($urandom_range(0, 7) == 0) req_b[b] = ~req_b[b];
      end
      if (amux_off) amux_off = ($urandom_range(0, 3) != 0);
      else          amux_off = ($urandom_range(0, 63) == 0);
      tick();
      tests_run++;
      if (observed() !== expected() || (sw_a_en & sw_b_en) !== '0 ||
          $countones(sw_a_en) > 1 || $countones(sw_b_en) > 1) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
    end
    $display("[TB] test_random done, %0d checks so far", tests_run);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_cross();
    test_amux_off();
    test_make_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
